ksa8_result_fifo: RTL

Downstream capture stage for the clocked 8-bit Kogge-Stone adder (KSA8). It tracks which clock cycles carry issued operands through the adder pipeline, samples {cout, sum7..sum0} when each result emerges, and buffers results in a small FIFO with a valid/ready output handshake. It also gives the operand source credit-based backpressure (in_ready) so results are never lost.

---
 rtl/ksa8_result_fifo_pkg.sv | 14 +
 rtl/ksa8_result_fifo_valid_delay.sv | 36 +++
 rtl/ksa8_result_fifo.sv | 110 +++++++++++
 3 files changed

// File: rtl/ksa8_result_fifo_pkg.sv
// Shared types and defaults for the KSA8 result capture stage.
// A result is the 9-bit word {cout, sum[7:0]} sampled from the adder.
package ksa8_result_fifo_pkg;

    localparam int unsigned RES_W       = 9;
    localparam int unsigned DEF_LATENCY = 5;
    localparam int unsigned DEF_DEPTH   = 8;

    typedef struct packed {
        logic       cout;
        logic [7:0] sum;
    } result_t;

endpackage

// File: rtl/ksa8_result_fifo_valid_delay.sv
// Valid-tracking shift register that mirrors the KSA8 pipeline depth.
// tap marks the cycle a result is present; inflight counts issues not yet captured.
module ksa8_valid_delay #(
    parameter int unsigned LATENCY = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       tap,
    output logic [4:0] inflight
);

    logic [LATENCY-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= in_valid;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign tap = sr_q[LATENCY-1];

    // Tap bit is still counted: its result is captured on the coming edge.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            inflight = inflight + 5'(sr_q[i]);
        end
    end

endmodule

// File: rtl/ksa8_result_fifo.sv
// Captures KSA8 results when their issue emerges from the pipeline and buffers them
// in a first-word fall-through FIFO with credit-based backpressure to the issuer.
module ksa8_result_fifo
    import ksa8_result_fifo_pkg::*;
#(
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned DEPTH   = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sum0,
    input  logic             sum1,
    input  logic             sum2,
    input  logic             sum3,
    input  logic             sum4,
    input  logic             sum5,
    input  logic             sum6,
    input  logic             sum7,
    input  logic             cout,
    output logic [RES_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       count,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

    logic          tap;
    logic [4:0]    inflight;
    result_t       wdata;
    result_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, pop, push, drop;

    ksa8_valid_delay #(
        .LATENCY (LATENCY)
    ) u_valid_delay (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .tap      (tap),
        .inflight (inflight)
    );

    always_comb begin
        wdata.cout = cout;
        wdata.sum  = {sum7, sum6, sum5, sum4, sum3, sum2, sum1, sum0};
    end

    assign full      = (count_q == DEPTH_C);
    assign out_valid = (count_q != 5'd0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts the tap result if the head leaves on the same edge.
    assign push      = tap && (!full || pop);
    assign drop      = tap && full && !pop;
    assign out_data  = mem[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Credits cover both stored entries and results still inside the adder.
    assign in_ready  = (6'(count_q) + 6'(inflight)) < 6'(DEPTH);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr_q] <= wdata;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
